// File: rtl/gb_pkg.sv
// Shared constants, FSM encoding and the stencil byte-index helper for the
// Gaussian-blur stencil window.
package gb_pkg;

  localparam int PIX_W     = 8;
  localparam int STENCIL_W = 9 * PIX_W;

  typedef enum logic {
    FILL,
    RUN
  } gb_state_e;

  // Byte slot of window element (row r, column c); r=0 is the oldest row,
  // c=0 the oldest column.
  function automatic int unsigned stencil_idx(input int unsigned r, input int unsigned c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/gb_stencil_window_if.sv
// Pixel input stream plus stencil output stream of gb_stencil_window.
// Optional st_TLAST is present when GB_STENCIL_TLAST_EN is defined.
interface gb_stencil_window_if;
  import gb_pkg::*;

  logic [PIX_W-1:0]     arg_1_TDATA;
  logic                 arg_1_TVALID;
  logic                 arg_1_TREADY;
  logic [STENCIL_W-1:0] st_TDATA;
  logic                 st_TVALID;
  logic                 st_TREADY;
`ifdef GB_STENCIL_TLAST_EN
  logic                 st_TLAST;

  modport master (
    output arg_1_TDATA, arg_1_TVALID, st_TREADY,
    input  arg_1_TREADY, st_TDATA, st_TVALID, st_TLAST
  );
  modport slave (
    input  arg_1_TDATA, arg_1_TVALID, st_TREADY,
    output arg_1_TREADY, st_TDATA, st_TVALID, st_TLAST
  );
`else
  modport master (
    output arg_1_TDATA, arg_1_TVALID, st_TREADY,
    input  arg_1_TREADY, st_TDATA, st_TVALID
  );
  modport slave (
    input  arg_1_TDATA, arg_1_TVALID, st_TREADY,
    output arg_1_TREADY, st_TDATA, st_TVALID
  );
`endif
endinterface

// File: rtl/gb_line_ram.sv
// Two-row line store: asynchronous read, synchronous write, a same-cycle
// read of the written address returns the old contents.
module gb_line_ram
  import gb_pkg::*;
#(
  parameter int DEPTH = 488,
  parameter int AW    = 9
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [2*PIX_W-1:0] wdata_i,
  output logic [2*PIX_W-1:0] rdata_o
);

  logic [2*PIX_W-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/gb_stencil_window.sv
// Raster-order pixel stream to 3x3 stencil stream for interior windows only.
// Define GB_STENCIL_TLAST_EN to add st_TLAST on the last window of a frame.
module gb_stencil_window #(
  parameter int IMG_W = 488,
  parameter int IMG_H = 648,
  parameter int X_W   = 9,
  parameter int Y_W   = 10
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  gb_stencil_window_if.slave   bus,
  output logic [X_W-1:0]       pix_x,
  output logic [Y_W-1:0]       pix_y
);
  import gb_pkg::*;

  gb_state_e            state_q;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [STENCIL_W-1:0] win_q, win_d;
  logic [STENCIL_W-1:0] st_data_q;
  logic                 st_valid_q;
  logic [2*PIX_W-1:0]   rd;
  logic [PIX_W-1:0]     ra, rb;
  logic                 ready, fire, emit, last_col, last_row;

  assign ready    = ~st_valid_q | bus.st_TREADY;
  assign fire     = bus.arg_1_TVALID & ready;
  assign last_col = (x_q == X_W'(IMG_W - 1));
  assign last_row = (y_q == Y_W'(IMG_H - 1));
  // RUN already implies y>=2; x>=2 masks columns carried over from the previous row.
  assign emit     = fire & (state_q == RUN) & (x_q >= X_W'(2));

  assign ra = rd[2*PIX_W-1:PIX_W];
  assign rb = rd[PIX_W-1:0];

  gb_line_ram #(
    .DEPTH (IMG_W),
    .AW    (X_W)
  ) u_line_ram (
    .clk_i   (ap_clk),
    .we_i    (fire),
    .addr_i  (x_q),
    .wdata_i ({rb, bus.arg_1_TDATA}),
    .rdata_o (rd)
  );

  always_comb begin
    win_d = win_q;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 2; c++) begin
        win_d[PIX_W*stencil_idx(r, c) +: PIX_W] = win_q[PIX_W*stencil_idx(r, c + 1) +: PIX_W];
      end
    end
    win_d[PIX_W*stencil_idx(0, 2) +: PIX_W] = ra;
    win_d[PIX_W*stencil_idx(1, 2) +: PIX_W] = rb;
    win_d[PIX_W*stencil_idx(2, 2) +: PIX_W] = bus.arg_1_TDATA;
  end

  always_comb begin
    x_d = x_q + X_W'(1);
    y_d = y_q;
    if (last_col) begin
      x_d = '0;
      y_d = last_row ? '0 : y_q + Y_W'(1);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (fire) win_q <= win_d;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= FILL;
      x_q        <= '0;
      y_q        <= '0;
      st_valid_q <= 1'b0;
      st_data_q  <= '0;
    end else begin
      if (fire) begin
        x_q <= x_d;
        y_q <= y_d;
        case (state_q)
          FILL:    if (last_col && y_q == Y_W'(1)) state_q <= RUN;
          RUN:     if (last_col && last_row)       state_q <= FILL;
          default: state_q <= FILL;
        endcase
      end
      if (emit) begin
        st_valid_q <= 1'b1;
        st_data_q  <= win_d;
      end else if (bus.st_TREADY) begin
        st_valid_q <= 1'b0;
      end
    end
  end

`ifdef GB_STENCIL_TLAST_EN
  logic st_last_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)  st_last_q <= 1'b0;
    else if (emit)  st_last_q <= last_col & last_row;
  end

  assign bus.st_TLAST = st_last_q;
`endif

  assign bus.arg_1_TREADY = ready;
  assign bus.st_TDATA     = st_data_q;
  assign bus.st_TVALID    = st_valid_q;
  assign pix_x            = x_q;
  assign pix_y            = y_q;

endmodule

// File: tb/tb_gb_stencil_window.sv
// Scoreboard bench for gb_stencil_window on a 4x4 image (pixel = 16*y + x).
module tb_gb_stencil_window;
  import gb_pkg::*;

  localparam int W = 4;
  localparam int H = 4;
  localparam logic [71:0] FIRST_ST = 72'h222120121110020100;

  typedef struct packed {
    logic [71:0] d;
    logic        last;
  } exp_t;

  logic       ap_clk = 1'b0;
  logic       ap_rst_n = 1'b0;
  logic [1:0] pix_x, pix_y;

  gb_stencil_window_if bus();

  gb_stencil_window #(
    .IMG_W (W),
    .IMG_H (H),
    .X_W   (2),
    .Y_W   (2)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus),
    .pix_x    (pix_x),
    .pix_y    (pix_y)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  exp_t        sb[$];
  int          p22_cyc;
  int          first_cyc;
  logic [71:0] first_d;

  function automatic logic [71:0] exp_st(input logic [7:0] fb, input int x, input int y);
    logic [71:0] s;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s[8*(3*r+c) +: 8] = fb | 8'(16*(y-2+r) + (x-2+c));
    return s;
  endfunction

  task automatic drive_pixel(input logic [7:0] d, input bit gaps, output int fire_cyc);
    int n;
    bit taken;
    if (gaps) while ($urandom_range(1, 0) == 1) begin @(posedge ap_clk); #1; end
    bus.arg_1_TDATA  = d;
    bus.arg_1_TVALID = 1'b1;
    n = 0;
    taken = 1'b0;
    fire_cyc = -1;
    while (!taken && n < 200) begin
      @(negedge ap_clk);
      taken = bus.arg_1_TREADY;
      fire_cyc = cyc;
      @(posedge ap_clk); #1;
      n++;
    end
    bus.arg_1_TVALID = 1'b0;
    checks++;
    if (!taken) begin
      failures++;
      $display("FAIL drive_timeout pixel=%h accepted=0 required=1", d);
    end
  endtask

  // Streams one full frame while a monitor pops and compares every accepted stencil.
  task automatic run_frame(input logic [7:0] fb, input bit gaps, input int hold, output int held_o);
    int got, held, mcyc;
    got = 0; held = 0; mcyc = 0;
    p22_cyc = -1; first_cyc = -1; first_d = '0;
    sb.delete();
    bus.st_TREADY = (hold > 0) ? 1'b0 : 1'b1;
    fork
      begin
        for (int y = 0; y < H; y++)
          for (int x = 0; x < W; x++) begin
            int fc;
            exp_t e;
            drive_pixel(fb | 8'(16*y + x), gaps, fc);
            if (x >= 2 && y >= 2) begin
              e.d = exp_st(fb, x, y);
              e.last = (x == W-1) && (y == H-1);
              sb.push_back(e);
            end
            if (x == 2 && y == 2) p22_cyc = fc;
          end
      end
      begin
        while (got < (W-2)*(H-2) && mcyc < 2000) begin
          @(negedge ap_clk);
          mcyc++;
          if (bus.st_TVALID && first_cyc < 0) begin
            first_cyc = cyc;
            first_d = bus.st_TDATA;
          end
          if (bus.st_TVALID && bus.st_TREADY) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
              failures++;
              $display("FAIL stencil_extra got=%h required=none", bus.st_TDATA);
            end else begin
              e = sb.pop_front();
              if (bus.st_TDATA !== e.d) begin
                failures++;
                $display("FAIL stencil_data idx=%0d got=%h required=%h", got, bus.st_TDATA, e.d);
              end
`ifdef GB_STENCIL_TLAST_EN
              checks++;
              if (bus.st_TLAST !== e.last) begin
                failures++;
                $display("FAIL stencil_tlast idx=%0d got=%b required=%b", got, bus.st_TLAST, e.last);
              end
`endif
            end
            got++;
          end else if (bus.st_TVALID && held < hold) begin
            checks++;
            if (bus.st_TDATA !== FIRST_ST || bus.arg_1_TREADY !== 1'b0) begin
              failures++;
              $display("FAIL hold_stable cycle=%0d got data=%h ready=%b required data=%h ready=0",
                       held, bus.st_TDATA, bus.arg_1_TREADY, FIRST_ST);
            end
            held++;
          end
          @(posedge ap_clk); #1;
          bus.st_TREADY = (got == 0 && held < hold) ? 1'b0 :
                          (gaps ? 1'($urandom_range(1, 0)) : 1'b1);
        end
      end
    join
    bus.st_TREADY = 1'b1;
    held_o = held;
    checks++;
    if (got != (W-2)*(H-2) || sb.size() != 0) begin
      failures++;
      $display("FAIL stencil_count got=%0d leftover=%0d required=%0d leftover=0", got, sb.size(), (W-2)*(H-2));
    end
  endtask

  task automatic test_reset();
    bus.arg_1_TVALID = 1'b0;
    bus.arg_1_TDATA  = '0;
    bus.st_TREADY    = 1'b1;
    ap_rst_n = 1'b0;
    #12;
    checks++;
    if (bus.st_TVALID !== 1'b0 || bus.st_TDATA !== '0 || pix_x !== '0 || pix_y !== '0 || bus.arg_1_TREADY !== 1'b1) begin
      failures++;
      $display("FAIL reset_state got valid=%b data=%h x=%0d y=%0d ready=%b required 0/0/0/0/1",
               bus.st_TVALID, bus.st_TDATA, pix_x, pix_y, bus.arg_1_TREADY);
    end
`ifdef GB_STENCIL_TLAST_EN
    checks++;
    if (bus.st_TLAST !== 1'b0) begin
      failures++;
      $display("FAIL reset_tlast got=%b required=0", bus.st_TLAST);
    end
`endif
    @(negedge ap_clk) ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
  endtask

  task automatic check_after_frame(input string name);
    checks++;
    if (pix_x !== '0 || pix_y !== '0) begin
      failures++;
      $display("FAIL %s_wrap got x=%0d y=%0d required x=0 y=0", name, pix_x, pix_y);
    end
    repeat (3) @(posedge ap_clk);
    #1;
    checks++;
    if (bus.st_TVALID !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle got valid=%b required=0", name, bus.st_TVALID);
    end
  endtask

  task automatic test_full_frame();
    int h;
    run_frame(8'h00, 1'b0, 0, h);
    checks++;
    if (first_cyc != p22_cyc + 1) begin
      failures++;
      $display("FAIL first_latency got cycle=%0d required=%0d", first_cyc, p22_cyc + 1);
    end
    checks++;
    if (first_d !== FIRST_ST) begin
      failures++;
      $display("FAIL first_stencil got=%h required=%h", first_d, FIRST_ST);
    end
    check_after_frame("full");
  endtask

  task automatic test_backpressure();
    int h;
    run_frame(8'h00, 1'b0, 5, h);
    checks++;
    if (h != 5) begin
      failures++;
      $display("FAIL hold_cycles got=%0d required=5", h);
    end
    check_after_frame("bp");
  endtask

  task automatic test_back_to_back();
    int h;
    run_frame(8'h00, 1'b0, 0, h);
    run_frame(8'h80, 1'b0, 0, h);
    checks++;
    if (first_d[7:0] !== 8'h80 || first_d !== exp_st(8'h80, 2, 2)) begin
      failures++;
      $display("FAIL frame2_first got=%h required=%h", first_d, exp_st(8'h80, 2, 2));
    end
    checks++;
    if (first_cyc != p22_cyc + 1) begin
      failures++;
      $display("FAIL frame2_early got cycle=%0d required=%0d", first_cyc, p22_cyc + 1);
    end
    check_after_frame("b2b");
  endtask

  task automatic test_reset_midframe();
    int fc, h;
    bus.st_TREADY = 1'b1;
    for (int i = 0; i < 8; i++) drive_pixel(8'(16*(i/W) + (i%W)), 1'b0, fc);
    checks++;
    if (pix_x !== 2'd0 || pix_y !== 2'd2) begin
      failures++;
      $display("FAIL midframe_pos got x=%0d y=%0d required x=0 y=2", pix_x, pix_y);
    end
    #2 ap_rst_n = 1'b0;
    #1;
    checks++;
    if (bus.st_TVALID !== 1'b0 || pix_x !== '0 || pix_y !== '0) begin
      failures++;
      $display("FAIL async_reset got valid=%b x=%0d y=%0d required 0/0/0", bus.st_TVALID, pix_x, pix_y);
    end
    @(negedge ap_clk) ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    run_frame(8'h00, 1'b0, 0, h);
    checks++;
    if (first_d !== FIRST_ST) begin
      failures++;
      $display("FAIL post_reset_first got=%h required=%h", first_d, FIRST_ST);
    end
    check_after_frame("rst");
  endtask

  task automatic test_random();
    int h;
    for (int k = 0; k < 3; k++) run_frame(8'h00, 1'b1, 0, h);
    check_after_frame("rand");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
